// File: rtl/sfifo_wr_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sfifo_wr_packer                                                            |
// | Packs RATIO narrow beats into one keep/last-tagged word for the sync FIFO. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sfifo_wr_packer #(
    parameter int IN_WIDTH     = 8,
    parameter int RATIO        = 4,
    parameter int FLUSH_CYCLES = 0,
    localparam int W           = RATIO*IN_WIDTH + RATIO + 1
) (
    input  logic                wclk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_last,
    input  logic                sfifo_full,
    output logic                wr,
    output logic [W-1:0]        wr_data,
    output logic [15:0]         pkt_cnt,
    output logic                busy
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int DW = RATIO*IN_WIDTH;
    localparam logic [CW-1:0] c_LAST_LANE = CW'(RATIO-1);

    logic [DW-1:0]    r_acc;
    logic [RATIO-1:0] r_keep;
    logic [CW-1:0]    r_cnt;
    logic [W-1:0]     r_hold;
    logic             r_hold_valid;
    logic [15:0]      r_pkt_cnt;

    logic             w_wr;
    logic             w_accept;
    logic             w_complete;
    logic             w_flush;
    logic [DW-1:0]    w_acc_ld;
    logic [RATIO-1:0] w_keep_ld;

    assign w_wr       = r_hold_valid & ~sfifo_full;
    assign in_ready   = ~r_hold_valid | w_wr;
    assign w_accept   = in_valid & in_ready;
    assign w_complete = w_accept & (in_last | (r_cnt == c_LAST_LANE));

    // Accumulator and keep mask as they would look with the current beat loaded
    for (genvar l = 0; l < RATIO; l++) begin : g_lane
        localparam logic [CW-1:0] c_LANE = CW'(l);
        assign w_acc_ld[l*IN_WIDTH +: IN_WIDTH] =
            (r_cnt == c_LANE) ? in_data : r_acc[l*IN_WIDTH +: IN_WIDTH];
        assign w_keep_ld[l] = (r_cnt == c_LANE) | r_keep[l];
    end

    if (FLUSH_CYCLES > 0) begin : g_flush
        localparam int IDW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
        localparam logic [IDW-1:0] c_IDLE_MAX = IDW'(FLUSH_CYCLES-1);
        logic [IDW-1:0] r_idle;

        // r_idle counts idle cycles already elapsed, so the FLUSH_CYCLES-th idle
        // cycle is the one that closes the partial word.
        always_ff @(posedge wclk or negedge rst_n) begin
            if (!rst_n) begin
                r_idle <= '0;
            end else if (w_accept || (r_cnt == '0) || w_flush) begin
                r_idle <= '0;
            end else if (r_idle != c_IDLE_MAX) begin
                r_idle <= r_idle + 1'b1;
            end
        end

        assign w_flush = (r_idle == c_IDLE_MAX) & (r_cnt != '0) & in_ready & ~w_accept;
    end else begin : g_no_flush
        assign w_flush = 1'b0;
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_keep       <= '0;
            r_cnt        <= '0;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_pkt_cnt    <= '0;
        end else begin
            if (w_complete) begin
                r_hold       <= {in_last, w_keep_ld, w_acc_ld};
                r_hold_valid <= 1'b1;
            end else if (w_flush) begin
                r_hold       <= {1'b0, r_keep, r_acc};
                r_hold_valid <= 1'b1;
            end else if (w_wr) begin
                r_hold_valid <= 1'b0;
            end

            if (w_complete || w_flush) begin
                r_acc  <= '0;
                r_keep <= '0;
                r_cnt  <= '0;
            end else if (w_accept) begin
                r_acc  <= w_acc_ld;
                r_keep <= w_keep_ld;
                r_cnt  <= r_cnt + 1'b1;
            end

            if (w_wr && r_hold[W-1]) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end

    assign wr      = w_wr;
    assign wr_data = r_hold;
    assign pkt_cnt = r_pkt_cnt;
    assign busy    = r_hold_valid | (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_sfifo_wr_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sfifo_wr_packer                                                         |
// | Scoreboard bench: main DUT without timeout, second DUT with FLUSH_CYCLES=3.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sfifo_wr_packer;

    localparam int W = 37;

    logic        wclk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, sfifo_full;
    logic [7:0]  in_data;
    logic        in_ready, wr, busy;
    logic [W-1:0] wr_data;
    logic [15:0] pkt_cnt;

    logic        b_valid, b_last, b_full;
    logic [7:0]  b_data;
    logic        b_ready, b_wr, b_busy;
    logic [W-1:0] b_wr_data;
    logic [15:0] b_pkt_cnt;

    int total = 0;
    int bad   = 0;
    int wr_pulses = 0;

    logic [W-1:0] sb_q[$];
    logic [31:0]  m_lanes;
    logic [3:0]   m_keep;
    int           m_cnt;
    int           m_pkts;
    bit           rand_on;

    always #5 wclk = ~wclk;

    sfifo_wr_packer #(.IN_WIDTH(8), .RATIO(4), .FLUSH_CYCLES(0)) dut_a (
        .wclk(wclk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .sfifo_full(sfifo_full),
        .wr(wr), .wr_data(wr_data), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    sfifo_wr_packer #(.IN_WIDTH(8), .RATIO(4), .FLUSH_CYCLES(3)) dut_b (
        .wclk(wclk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_last(b_last), .sfifo_full(b_full),
        .wr(b_wr), .wr_data(b_wr_data), .pkt_cnt(b_pkt_cnt), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_lanes = '0;
        m_keep  = '0;
        m_cnt   = 0;
    endtask

    // Reference packing of accepted beats into expected FIFO words
    task automatic model_beat(input logic [7:0] d, input logic l);
        m_lanes[m_cnt*8 +: 8] = d;
        m_keep[m_cnt] = 1'b1;
        if (m_cnt == 3 || l) begin
            sb_q.push_back({l, m_keep, m_lanes});
            if (l) m_pkts++;
            model_clear();
        end else begin
            m_cnt++;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        forever begin
            @(negedge wclk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 64'(in_ready), 64'd1);
                break;
            end
            @(posedge wclk); #1;
        end
        @(posedge wclk); #1;
        in_valid = 1'b0;
        model_beat(d, l);
    endtask

    task automatic drain();
        int n;
        n = 0;
        forever begin
            @(negedge wclk);
            if (sb_q.size() == 0 && !busy) break;
            n++;
            if (n > 300) begin
                chk("drain_timeout", 64'(sb_q.size()), 64'd0);
                break;
            end
        end
        @(posedge wclk); #1;
    endtask

    // Output monitor: pops the scoreboard on every FIFO write
    always @(negedge wclk) begin
        if (rst_n) begin
            chk("wr_while_full", 64'(wr & sfifo_full), 64'd0);
            if (wr) begin
                wr_pulses++;
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) chk("wr_data", 64'(wr_data), 64'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wp0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sfifo_full = 1'b0;
        b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_full = 1'b0;
        rand_on = 1'b0; m_pkts = 0;
        model_clear();
        #3;
        chk("rst_wr", 64'(wr), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        repeat (2) @(posedge wclk);
        #1 rst_n = 1'b1;
        @(posedge wclk); #1;

        // Full packet streamed back-to-back, one-cycle write latency
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        @(negedge wclk);
        chk("stream_wr_latency", 64'(wr), 64'd1);
        chk("stream_word", 64'(wr_data), 64'({1'b1, 4'hF, 32'h44332211}));
        @(posedge wclk); #1;
        chk("stream_pkt_cnt", 64'(pkt_cnt), 64'd1);
        drain();

        // Short packet, then a fresh beat that must start in lane 0
        send(8'hA1, 1'b0); send(8'hB2, 1'b1);
        @(negedge wclk);
        chk("short_word", 64'(wr_data), 64'({1'b1, 4'h3, 32'h0000B2A1}));
        @(posedge wclk); #1;
        send(8'h77, 1'b1);
        drain();
        chk("short_pkt_cnt", 64'(pkt_cnt), 64'd3);

        // Backpressure: held word frozen for 5 cycles, released exactly once
        sfifo_full = 1'b1;
        wp0 = wr_pulses;
        send(8'h10, 1'b0); send(8'h11, 1'b0); send(8'h12, 1'b0); send(8'h13, 1'b1);
        repeat (5) begin
            @(negedge wclk);
            chk("bp_wr", 64'(wr), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold", 64'(wr_data), 64'({1'b1, 4'hF, 32'h13121110}));
        end
        @(posedge wclk); #1;
        sfifo_full = 1'b0;
        send(8'h20, 1'b0); send(8'h21, 1'b0); send(8'h22, 1'b0); send(8'h23, 1'b1);
        drain();
        chk("bp_pulses", 64'(wr_pulses - wp0), 64'd2);
        chk("bp_pkt_cnt", 64'(pkt_cnt), 64'd5);

        // Reset with two beats in the accumulator
        send(8'hC1, 1'b0); send(8'hC2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", 64'(wr), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        model_clear();
        m_pkts = 0;
        @(posedge wclk); #1 rst_n = 1'b1;
        @(posedge wclk); #1;
        send(8'h55, 1'b1);
        @(negedge wclk);
        chk("post_rst_word", 64'(wr_data), 64'({1'b1, 4'h1, 32'h00000055}));
        drain();

        // Timeout flush on the FLUSH_CYCLES=3 instance
        for (int i = 0; i < 3; i++) begin
            b_valid = 1'b1;
            b_data  = 8'(i + 1);
            @(negedge wclk);
            chk("flush_in_ready", 64'(b_ready), 64'd1);
            @(posedge wclk); #1;
        end
        b_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge wclk);
            chk("flush_wr_timing", 64'(b_wr), 64'(k == 4));
        end
        chk("flush_word", 64'(b_wr_data), 64'({1'b0, 4'h7, 32'h00030201}));
        @(posedge wclk); #1;
        chk("flush_pkt_cnt", 64'(b_pkt_cnt), 64'd0);
        chk("flush_busy", 64'(b_busy), 64'd0);

        // Randomised packets with random gaps and random FIFO-full
        rand_on = 1'b1;
        fork
            begin
                while (rand_on) begin
                    @(posedge wclk); #1;
                    sfifo_full = ($urandom_range(0, 2) == 0);
                end
                sfifo_full = 1'b0;
            end
        join_none
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 17);
            for (int b = 0; b < len; b++) begin
                send(8'($urandom), b == len - 1);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge wclk);
                #0;
            end
        end
        rand_on = 1'b0;
        repeat (2) @(posedge wclk);
        #2;
        drain();
        chk("rand_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("rand_pkt_cnt", 64'(pkt_cnt), 64'(16'(m_pkts)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
